bsg_vanilla_remote_load_scoreboard: RTL and testbench

Parametrised per-register scoreboard tracking outstanding remote loads for the vanilla core's integer and FP register files. It is the successor to the single-bit pending scoreboard: each register gets a saturating outstanding-count, a global cap limits in-flight loads, and illegal clears are flagged. It sits between ID/EXE (score on remote-load issue, dependency query for rs1/rs2/rs3/rd) and the network response path (clear on remote load response writeback).

---
 rtl/bsg_vanilla_remote_load_scoreboard_if.sv | 44 ++++
 rtl/bsg_vanilla_remote_load_scoreboard.sv | 93 +++++++++
 tb/tb_bsg_vanilla_remote_load_scoreboard.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/bsg_vanilla_remote_load_scoreboard_if.sv
// Bundle of the scoreboard's issue (score), writeback (clear) and
// dependency-query signals.
//   master : ID/EXE + response path side, drives score/clear/query requests
//   slave  : the scoreboard, returns ready, dependencies, counts and error
// Signals:
//   score_v_i/score_float_i/score_id_i, score_ready_o  - remote load issue
//   clear_v_i/clear_float_i/clear_id_i                 - response writeback
//   query_float_i/query_id_i, query_dep_o              - dependency queries
//   outstanding_o, empty_o, clear_err_o                - global status
interface bsg_vanilla_remote_load_scoreboard_if #(
  parameter int els_p       = 32,
  parameter int max_out_p   = 16,
  parameter int num_query_p = 4,
  parameter int id_width_p  = $clog2(els_p),
  parameter int out_width_p = $clog2(max_out_p+1)
);
  logic                              score_v_i;
  logic                              score_float_i;
  logic [id_width_p-1:0]             score_id_i;
  logic                              score_ready_o;
  logic                              clear_v_i;
  logic                              clear_float_i;
  logic [id_width_p-1:0]             clear_id_i;
  logic [num_query_p-1:0]            query_float_i;
  logic [num_query_p*id_width_p-1:0] query_id_i;
  logic [num_query_p-1:0]            query_dep_o;
  logic [out_width_p-1:0]            outstanding_o;
  logic                              empty_o;
  logic                              clear_err_o;

  modport master (
    output score_v_i, score_float_i, score_id_i,
           clear_v_i, clear_float_i, clear_id_i,
           query_float_i, query_id_i,
    input  score_ready_o, query_dep_o, outstanding_o, empty_o, clear_err_o
  );

  modport slave (
    input  score_v_i, score_float_i, score_id_i,
           clear_v_i, clear_float_i, clear_id_i,
           query_float_i, query_id_i,
    output score_ready_o, query_dep_o, outstanding_o, empty_o, clear_err_o
  );
endinterface

// File: rtl/bsg_vanilla_remote_load_scoreboard.sv
// Per-register outstanding remote-load scoreboard for the int (bank 0) and
// FP (bank 1) register files. Each register keeps a saturating count of
// in-flight loads; a global counter caps total in-flight loads; clearing a
// register with no outstanding load raises a sticky error.
// Ports:
//   clk_i      - clock
//   reset_n_i  - asynchronous active-low reset
//   sb         - slave side of the scoreboard interface (score/clear/query)
module bsg_vanilla_remote_load_scoreboard #(
  parameter int els_p         = 32,
  parameter int count_width_p = 2,
  parameter int max_out_p     = 16,
  parameter int id_width_p    = $clog2(els_p),
  parameter int num_query_p   = 4
) (
  input logic clk_i,
  input logic reset_n_i,
  bsg_vanilla_remote_load_scoreboard_if.slave sb
);

  localparam int out_width_lp = $clog2(max_out_p+1);
  localparam logic [count_width_p-1:0] cnt_max_lp  = '1;
  localparam logic [out_width_lp-1:0]  tot_max_lp  = out_width_lp'(max_out_p);
  // Ids are zero-extended by one bit so the range check stays meaningful
  // when els_p is not a power of two.
  localparam logic [id_width_p:0]      els_lp      = (id_width_p+1)'(els_p);

  logic [count_width_p-1:0] cnt_r [2][els_p];
  logic [out_width_lp-1:0]  total_r;
  logic                     err_r;

  logic                     score_in_range, clear_in_range;
  logic                     score_x0, clear_x0;
  logic [count_width_p-1:0] score_cnt, clear_cnt;
  logic                     score_ready;
  logic                     score_inc, clear_do, clear_bad, clear_dec, same_reg;

  assign score_in_range = ({1'b0, sb.score_id_i} < els_lp);
  assign clear_in_range = ({1'b0, sb.clear_id_i} < els_lp);
  assign score_x0       = ~sb.score_float_i & (sb.score_id_i == '0);
  assign clear_x0       = ~sb.clear_float_i & (sb.clear_id_i == '0);
  assign score_cnt      = score_in_range ? cnt_r[sb.score_float_i][sb.score_id_i] : '0;
  assign clear_cnt      = clear_in_range ? cnt_r[sb.clear_float_i][sb.clear_id_i] : '0;

  // Ready depends only on registered state; a same-cycle clear never helps.
  // Int x0 is never counted, so its entry is always 0 and only the cap gates it.
  assign score_ready = score_in_range & (score_cnt != cnt_max_lp) & (total_r != tot_max_lp);

  assign score_inc = sb.score_v_i & score_ready & ~score_x0;
  assign clear_do  = sb.clear_v_i & ~clear_x0;
  assign clear_bad = clear_do & (~clear_in_range | (clear_cnt == '0));
  assign clear_dec = clear_do & ~clear_bad;
  // Increment and decrement of the same entry cancel out.
  assign same_reg  = score_inc & clear_dec
                   & (sb.score_float_i == sb.clear_float_i)
                   & (sb.score_id_i == sb.clear_id_i);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned b = 0; b < 2; b++)
        for (int unsigned i = 0; i < els_p; i++)
          cnt_r[b][i] <= '0;
      total_r <= '0;
      err_r   <= 1'b0;
    end else begin
      if (score_inc && !same_reg)
        cnt_r[sb.score_float_i][sb.score_id_i] <= score_cnt + 1'b1;
      if (clear_dec && !same_reg)
        cnt_r[sb.clear_float_i][sb.clear_id_i] <= clear_cnt - 1'b1;
      total_r <= total_r + out_width_lp'(score_inc) - out_width_lp'(clear_dec);
      if (clear_bad)
        err_r <= 1'b1;
    end
  end

  always_comb begin
    sb.query_dep_o = '0;
    for (int unsigned k = 0; k < num_query_p; k++) begin
      logic [id_width_p-1:0] qid;
      logic                  qf;
      qid = sb.query_id_i[k*id_width_p +: id_width_p];
      qf  = sb.query_float_i[k];
      if (({1'b0, qid} < els_lp) && !(!qf && qid == '0))
        sb.query_dep_o[k] = (cnt_r[qf][qid] != '0);
    end
  end

  assign sb.score_ready_o = score_ready;
  assign sb.outstanding_o = total_r;
  assign sb.empty_o       = (total_r == '0);
  assign sb.clear_err_o   = err_r;

endmodule

// File: tb/tb_bsg_vanilla_remote_load_scoreboard.sv
module tb_bsg_vanilla_remote_load_scoreboard;

  localparam int els_lp   = 32;
  localparam int cw_lp    = 2;
  localparam int maxo_lp  = 16;
  localparam int idw_lp   = 5;
  localparam int nq_lp    = 4;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  bsg_vanilla_remote_load_scoreboard_if #(
    .els_p(els_lp), .max_out_p(maxo_lp), .num_query_p(nq_lp), .id_width_p(idw_lp)
  ) sb_if ();

  bsg_vanilla_remote_load_scoreboard #(
    .els_p(els_lp), .count_width_p(cw_lp), .max_out_p(maxo_lp),
    .id_width_p(idw_lp), .num_query_p(nq_lp)
  ) dut (
    .clk_i(clk),
    .reset_n_i(reset_n),
    .sb(sb_if.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic score(input logic v, input logic f, input int id);
    sb_if.score_v_i     = v;
    sb_if.score_float_i = f;
    sb_if.score_id_i    = idw_lp'(id);
  endtask

  task automatic clear(input logic v, input logic f, input int id);
    sb_if.clear_v_i     = v;
    sb_if.clear_float_i = f;
    sb_if.clear_id_i    = idw_lp'(id);
  endtask

  task automatic setq(input int k, input logic f, input int id);
    sb_if.query_float_i[k]                = f;
    sb_if.query_id_i[k*idw_lp +: idw_lp]  = idw_lp'(id);
  endtask

  task automatic idle();
    score(1'b0, 1'b0, 0);
    clear(1'b0, 1'b0, 0);
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    sb_if.query_float_i = '0;
    sb_if.query_id_i    = '0;
    #1;
    check("rst_ready", 32'(sb_if.score_ready_o), 1);
    check("rst_out",   32'(sb_if.outstanding_o), 0);
    check("rst_empty", 32'(sb_if.empty_o), 1);
    check("rst_err",   32'(sb_if.clear_err_o), 0);
    check("rst_dep",   32'(sb_if.query_dep_o), 0);
    #6 reset_n = 1'b1;
    tick();

    // Reset mid-traffic
    setq(0, 1'b0, 5);
    score(1'b1, 1'b0, 5);
    tick(); tick(); tick();
    score(1'b0, 1'b0, 5);
    check("r5_out3", 32'(sb_if.outstanding_o), 3);
    check("r5_dep",  32'(sb_if.query_dep_o[0]), 1);
    #3 reset_n = 1'b0;
    #1;
    check("async_out",   32'(sb_if.outstanding_o), 0);
    check("async_empty", 32'(sb_if.empty_o), 1);
    check("async_dep",   32'(sb_if.query_dep_o[0]), 0);
    check("async_ready", 32'(sb_if.score_ready_o), 1);
    #2 reset_n = 1'b1;
    tick();
    clear(1'b1, 1'b0, 5);
    #1;
    check("err_before", 32'(sb_if.clear_err_o), 0);
    tick();
    idle();
    check("err_after_rst_clear", 32'(sb_if.clear_err_o), 1);
    check("out_after_bad_clear", 32'(sb_if.outstanding_o), 0);
    reset_pulse();

    // Per-register saturation on FP f7
    setq(0, 1'b1, 7);
    score(1'b1, 1'b1, 7);
    tick(); tick(); tick();
    check("f7_out3",  32'(sb_if.outstanding_o), 3);
    check("f7_ready", 32'(sb_if.score_ready_o), 0);
    tick();
    check("f7_sat_out", 32'(sb_if.outstanding_o), 3);
    score(1'b1, 1'b1, 8);
    #1;
    check("f8_ready", 32'(sb_if.score_ready_o), 1);
    score(1'b0, 1'b1, 7);
    clear(1'b1, 1'b1, 7);
    tick();
    clear(1'b0, 1'b1, 7);
    check("f7_ready_back", 32'(sb_if.score_ready_o), 1);
    check("f7_dep_2",      32'(sb_if.query_dep_o[0]), 1);
    check("f7_out2",       32'(sb_if.outstanding_o), 2);
    clear(1'b1, 1'b1, 7);
    tick();
    check("f7_dep_1", 32'(sb_if.query_dep_o[0]), 1);
    tick();
    idle();
    check("f7_dep_0", 32'(sb_if.query_dep_o[0]), 0);
    check("f7_out0",  32'(sb_if.outstanding_o), 0);
    check("f7_err",   32'(sb_if.clear_err_o), 0);

    // Global cap
    for (int i = 1; i <= 16; i++) begin
      score(1'b1, 1'b0, i);
      tick();
    end
    score(1'b1, 1'b0, 17);
    #1;
    check("cap_out16", 32'(sb_if.outstanding_o), 16);
    check("cap_empty", 32'(sb_if.empty_o), 0);
    check("cap_ready", 32'(sb_if.score_ready_o), 0);
    setq(1, 1'b0, 17);
    tick();
    check("cap_no_accept_out", 32'(sb_if.outstanding_o), 16);
    check("cap_no_accept_dep", 32'(sb_if.query_dep_o[1]), 0);
    score(1'b0, 1'b0, 17);
    clear(1'b1, 1'b0, 1);
    tick();
    clear(1'b0, 1'b0, 1);
    check("cap_ready_back", 32'(sb_if.score_ready_o), 1);
    check("cap_out15",      32'(sb_if.outstanding_o), 15);
    for (int i = 2; i <= 16; i++) begin
      clear(1'b1, 1'b0, i);
      tick();
    end
    idle();
    check("cap_drain_out", 32'(sb_if.outstanding_o), 0);
    check("cap_drain_err", 32'(sb_if.clear_err_o), 0);

    // Simultaneous score and clear
    setq(0, 1'b0, 3);
    setq(1, 1'b0, 4);
    score(1'b1, 1'b0, 3);
    tick();
    clear(1'b1, 1'b0, 3);
    tick();
    check("sim_same_out", 32'(sb_if.outstanding_o), 1);
    check("sim_same_dep", 32'(sb_if.query_dep_o[0]), 1);
    score(1'b1, 1'b0, 4);
    tick();
    idle();
    check("sim_diff_dep3", 32'(sb_if.query_dep_o[0]), 0);
    check("sim_diff_dep4", 32'(sb_if.query_dep_o[1]), 1);
    check("sim_diff_out",  32'(sb_if.outstanding_o), 1);
    clear(1'b1, 1'b0, 4);
    tick();
    idle();
    check("sim_drain_out", 32'(sb_if.outstanding_o), 0);

    // Bank separation and int x0
    setq(0, 1'b1, 9);
    setq(1, 1'b0, 9);
    setq(2, 1'b0, 0);
    score(1'b1, 1'b0, 9);
    tick();
    score(1'b1, 1'b0, 0);
    #1;
    check("bank_f9_dep", 32'(sb_if.query_dep_o[0]), 0);
    check("bank_r9_dep", 32'(sb_if.query_dep_o[1]), 1);
    check("x0_ready",    32'(sb_if.score_ready_o), 1);
    tick();
    score(1'b0, 1'b0, 0);
    check("x0_out",  32'(sb_if.outstanding_o), 1);
    check("x0_dep",  32'(sb_if.query_dep_o[2]), 0);
    clear(1'b1, 1'b0, 0);
    tick();
    check("x0_clear_err", 32'(sb_if.clear_err_o), 0);
    clear(1'b1, 1'b0, 9);
    tick();
    idle();
    check("bank_drain_out", 32'(sb_if.outstanding_o), 0);

    // Illegal clear of FP f2, sticky error
    setq(3, 1'b1, 2);
    clear(1'b1, 1'b1, 2);
    tick();
    idle();
    check("ill_err",  32'(sb_if.clear_err_o), 1);
    check("ill_out",  32'(sb_if.outstanding_o), 0);
    check("ill_dep",  32'(sb_if.query_dep_o[3]), 0);
    score(1'b1, 1'b0, 6);
    tick();
    score(1'b0, 1'b0, 6);
    clear(1'b1, 1'b0, 6);
    tick();
    idle();
    check("ill_sticky", 32'(sb_if.clear_err_o), 1);
    check("ill_out_end", 32'(sb_if.outstanding_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
